sync_fifo_flags: RTL
====================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 6, number of entries (>=2); it SHALL NOT be required to be a power of two.
REQ-003 Parameter AF_TH, default FIFO_DEPTH-1, almost-full threshold (1..FIFO_DEPTH).
REQ-004 Parameter AE_TH, default 1, almost-empty threshold (0..FIFO_DEPTH-1).
REQ-005 One clock; reset is asynchronous and active-low: i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_wr_en  in  1  write request.
REQ-008 i_wr_data  in  DATA_WIDTH  write word.
REQ-009 i_rd_en  in  1  read request (pop in FWFT mode).
REQ-010 i_clr_err  in  1  clear the sticky error flags.
REQ-011 o_rd_data  out  DATA_WIDTH  read word.
REQ-012 o_rd_valid  out  1  o_rd_data is valid.
REQ-013 o_full / o_empty  out  1 each  occupancy == FIFO_DEPTH / occupancy == 0.
REQ-014 o_almost_full / o_almost_empty  out  1 each  occupancy >= AF_TH / occupancy <= AE_TH.
REQ-015 o_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
REQ-016 o_overflow / o_underflow  out  1 each  sticky error flags.

Function
REQ-017 rd_acc = i_rd_en && !o_empty; wr_acc = i_wr_en && (!o_full || rd_acc).
REQ-018 Write when full with a simultaneous accepted read: both accepted; count unchanged; o_full stays 1.
REQ-019 Read when empty with a simultaneous write: read rejected, write accepted; count becomes 1 at the next edge.
REQ-020 Write and read pointers SHALL run 0..FIFO_DEPTH-1 and wrap to 0 after FIFO_DEPTH-1, for any depth.
REQ-021 o_count SHALL update at the edge of acceptance: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 o_full, o_empty, o_almost_full and o_almost_empty SHALL be decoded from the registered count, with no further latency.
REQ-023 A written word SHALL be readable no earlier than the cycle after its write edge; same-address bypass is excluded.
REQ-024 o_overflow SHALL set when i_wr_en && !wr_acc; o_underflow SHALL set when i_rd_en && !rd_acc.
REQ-025 Error flags SHALL hold until a cycle with i_clr_err=1 clears them; a set in the same cycle as the clear wins.
REQ-026 A rejected write or read SHALL NOT change pointers, count or memory.
REQ-027 Illegal parameter values (FIFO_DEPTH<2, AF_TH or AE_TH out of range) SHALL cause an elaboration failure.

Reset
REQ-028 On i_rst_n low, immediately and regardless of clock: pointers=0, o_count=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0.
REQ-029 On i_rst_n low: o_overflow=0, o_underflow=0, o_rd_data=0, o_rd_valid=0.
REQ-030 Memory array contents are not reset; they are unobservable until rewritten.
REQ-031 Reset asserted mid-burst SHALL discard all contents; the first read after release returns the first post-reset write.

Configuration
REQ-032 Macro SYNC_FIFO_FWFT_EN selects the read mode.
REQ-033 Undefined (standard): o_rd_data registered, loaded on rd_acc, valid on the cycle after rd_acc; o_rd_valid is a 1-cycle pulse then; o_rd_data otherwise holds the last value.
REQ-034 Defined (FWFT): o_rd_data shows the head entry whenever !o_empty; o_rd_valid = !o_empty; i_rd_en pops the head at the edge; all flag and count rules unchanged.

Verification
REQ-035 Defaults, standard mode; write 0x11..0x16 on 6 cycles -> count 1..6; almost_full at count 5, full at 6; 7th write sets o_overflow; count stays 6.
REQ-036 Full FIFO, wr+rd same cycle, data 0x77 -> 0x11 read out, count stays 6; after 6 further reads, the last word read is 0x77.
REQ-037 Empty FIFO, wr 0xA5 + rd same cycle -> o_underflow=1, count=1; read next cycle -> o_rd_data=0xA5 with o_rd_valid one cycle later.
REQ-038 Wrap with depth 6: perform 10 write/read pairs of 0x00..0x09 -> in-order data, pointers wrap after index 5, no errors.
REQ-039 Set both error flags, then pulse i_clr_err with a concurrent overflow -> o_overflow stays 1, o_underflow clears.
REQ-040 SYNC_FIFO_FWFT_EN defined: write 0x3C to the empty FIFO -> next cycle o_rd_valid=1, o_rd_data=0x3C; one i_rd_en -> empty; assert reset mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered occupancy count, decoded flags and sticky overflow/underflow errors.
// Read mode: standard registered read by default; first-word-fall-through when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 6,
  parameter int AF_TH      = FIFO_DEPTH - 1,
  parameter int AE_TH      = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_wr_en,
  input  logic [DATA_WIDTH-1:0]           i_wr_data,
  input  logic                            i_rd_en,
  input  logic                            i_clr_err,
  output logic [DATA_WIDTH-1:0]           o_rd_data,
  output logic                            o_rd_valid,
  output logic                            o_full,
  output logic                            o_empty,
  output logic                            o_almost_full,
  output logic                            o_almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
  output logic                            o_overflow,
  output logic                            o_underflow
);
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: FIFO_DEPTH must be >= 2");
  end
  if (AF_TH < 1 || AF_TH > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_TH must be in 1..FIFO_DEPTH");
  end
  if (AE_TH < 0 || AE_TH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_TH must be in 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rd_acc, wr_acc;

  // Flags come straight off the registered count.
  assign o_full         = (count_q == CW'(FIFO_DEPTH));
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= CW'(AF_TH));
  assign o_almost_empty = (count_q <= CW'(AE_TH));
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

  // A write into a full FIFO is still taken when a read frees the slot this edge.
  assign rd_acc = i_rd_en && !o_empty;
  assign wr_acc = i_wr_en && (!o_full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // New error events take priority over a same-cycle clear.
    ovf_d = (ovf_q && !i_clr_err) || (i_wr_en && !wr_acc);
    udf_d = (udf_q && !i_clr_err) || (i_rd_en && !rd_acc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately unreset; stale words are never exposed because the count gates reads.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rd_data  = o_empty ? '0 : mem_q[rd_ptr_q];
  assign o_rd_valid = !o_empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
`endif

endmodule
